led_pattern: RTL and testbench
==============================

LED_PATTERN -- requirements
Module: led_pattern

Interface
REQ-001 Parameter CLK_FREQ, default 12_000_000, SHALL give the CLK frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000, SHALL give the internal tick rate in Hz; TICK_DIV = CLK_FREQ/TICK_HZ, integer and >= 2.
REQ-003 Parameter NUM_CH, default 3, SHALL give the number of independent LED channels (1..16).
REQ-004 Parameter PER_W, default 16, SHALL give the width of the period field, in ticks.
REQ-005 Parameter RESET_MODE, default 2 (BLINK), SHALL give the mode every channel takes at reset.
REQ-006 Parameter RESET_PERIOD, default 1000, SHALL give the period in ticks every channel takes at reset.
REQ-007 Parameter ACTIVE_LOW, default 0, SHALL invert all LED outputs when 1.
REQ-008 CLK  in  1  SHALL be the single system clock.
REQ-009 RST  in  1  SHALL be the synchronous, active-high reset.
REQ-010 wr_en  in  1  SHALL be the configuration write strobe, sampled on each CLK rising edge.
REQ-011 wr_ch  in  CH_W = max(1, clog2(NUM_CH))  SHALL be the target channel index.
REQ-012 wr_mode  in  2  SHALL be the mode to write: 0 OFF, 1 ON, 2 BLINK, 3 STROBE.
REQ-013 wr_period  in  PER_W  SHALL be the period to write, in ticks.
REQ-014 LED  out  NUM_CH  SHALL be the registered LED drive, one bit per channel.
REQ-015 tick  out  1  SHALL be a one-CLK pulse at TICK_HZ.

Function
REQ-016 The prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for exactly the one cycle in which it holds TICK_DIV-1.
REQ-017 Each channel SHALL hold mode (2 b), period (PER_W b) and phase (PER_W b).
REQ-018 The effective period SHALL be max(period, 2); stored values 0 and 1 are clamped on use, not on write.
REQ-019 On tick, phase SHALL advance to phase+1, or wrap to 0 when phase >= effective period - 1; it SHALL not advance without tick.
REQ-020 On-state: OFF = 0; ON = 1; BLINK = (phase < effective period >> 1); STROBE = (phase == 0).
REQ-021 LED[i] SHALL equal on-state XOR ACTIVE_LOW, registered, so it lags phase and mode by exactly one CLK.
REQ-022 A write with wr_en=1 and wr_ch < NUM_CH SHALL load that channel's mode and period and clear its phase to 0, all visible in the next cycle.
REQ-023 A write with wr_ch >= NUM_CH SHALL be ignored and SHALL leave all state unchanged.
REQ-024 When a write and a tick hit the same channel in the same cycle, the write SHALL win and phase SHALL become 0.
REQ-025 A write SHALL not affect the prescaler or any other channel; writes are accepted every cycle, with no back-pressure.
REQ-026 A phase left above the new effective period after a write SHALL NOT occur, because a write always clears phase.

Reset
REQ-027 While RST=1, the prescaler and every phase SHALL be 0, mode SHALL be RESET_MODE, period SHALL be RESET_PERIOD, tick SHALL be 0, and LED SHALL be {NUM_CH{ACTIVE_LOW}}.
REQ-028 RST SHALL take priority over a write in the same cycle; assertion mid-period SHALL discard all progress.
REQ-029 After RST falls, the first tick SHALL occur on the TICK_DIV-th rising edge.

Structure
REQ-030 Mode encodings, CH_W and the clamp rule SHALL be defined as constants in the shared package led_pkg.
REQ-031 The prescaler SHALL be the sub-module tick_gen (CLK, RST, tick), parametrised by CLK_FREQ and TICK_HZ.
REQ-032 The channels SHALL be a generate loop inside led_pattern, not a separate module.

Verification (CLK_FREQ=100, TICK_HZ=10, NUM_CH=3, PER_W=8, RESET_PERIOD=4, RESET_MODE=2)
REQ-033 Release RST -> tick pulses every 10 CLK, first on edge 10; LED = 3'b111 for ticks 0-1, 3'b000 for ticks 2-3, and so on.
REQ-034 Write ch1 STROBE with period 5 -> LED[1] high for one tick interval in every 5; ch0 and ch2 are undisturbed.
REQ-035 Write ch2 with period 0, then period 1 -> both behave as period 2 (toggles every tick); write ch0 OFF -> LED[0]=0 on the second edge after the write.
REQ-036 Write ch0 BLINK period 6 in the same cycle as tick -> phase=0 the next cycle; LED[0] is high for 3 ticks, low for 3.
REQ-037 Write with wr_ch=3 -> no change in any LED or phase; assert RST mid-pattern -> LED=0 and tick=0 on the next edge.
REQ-038 ACTIVE_LOW=1 -> every LED waveform above is inverted, including the reset value 3'b111.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED pattern generator: mode encodings, channel-index width
// and the period clamp applied when a stored period is used.
package led_pkg;

    typedef enum logic [1:0] {
        ModeOff    = 2'd0,
        ModeOn     = 2'd1,
        ModeBlink  = 2'd2,
        ModeStrobe = 2'd3
    } mode_e;

    localparam int unsigned MinPeriod = 2;

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Stored periods of 0 or 1 are legal; they behave as the shortest usable period.
    function automatic int unsigned clamp_period(input int unsigned period);
        return (period < MinPeriod) ? MinPeriod : period;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the cycle holding the terminal count.
module tick_gen #(
    parameter int unsigned CLK_FREQ = 12_000_000,
    parameter int unsigned TICK_HZ  = 1000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int unsigned TickDiv = CLK_FREQ / TICK_HZ;
    localparam int unsigned CntW    = $clog2(TickDiv);
    localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntMax) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/led_pattern.sv
// Multi-channel LED pattern generator: each channel runs OFF/ON/BLINK/STROBE against
// a shared tick, with a per-channel phase counter reloaded by configuration writes.
module led_pattern
    import led_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 12_000_000,
    parameter int unsigned TICK_HZ      = 1000,
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned PER_W        = 16,
    parameter int unsigned RESET_MODE   = 2,
    parameter int unsigned RESET_PERIOD = 1000,
    parameter bit          ACTIVE_LOW   = 1'b0,
    localparam int unsigned CH_W        = ch_width(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_mode,
    input  logic [PER_W-1:0]  wr_period,
    output logic [NUM_CH-1:0] LED,
    output logic              tick
);

    localparam mode_e            ResetMode = mode_e'(2'(RESET_MODE));
    localparam logic [PER_W-1:0] ResetPer  = PER_W'(RESET_PERIOD);

    tick_gen #(
        .CLK_FREQ(CLK_FREQ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .CLK (CLK),
        .RST (RST),
        .tick(tick)
    );

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        mode_e            mode_q, mode_d;
        logic [PER_W-1:0] period_q, period_d;
        logic [PER_W-1:0] phase_q, phase_d;
        logic [PER_W-1:0] eff_per;
        logic             led_q, led_d;
        logic             hit;

        // Out-of-range indices never compare equal to a real channel, so they are dropped.
        assign hit = wr_en && (wr_ch == CH_W'(gi));

        always_comb begin
            logic on;
            mode_d   = mode_q;
            period_d = period_q;
            phase_d  = phase_q;
            on       = 1'b0;
            eff_per  = PER_W'(clamp_period(32'(period_q)));

            if (hit) begin
                mode_d   = mode_e'(wr_mode);
                period_d = wr_period;
                phase_d  = '0;
            end else if (tick) begin
                phase_d = (phase_q >= eff_per - PER_W'(1)) ? '0 : phase_q + PER_W'(1);
            end

            unique case (mode_q)
                ModeOff:    on = 1'b0;
                ModeOn:     on = 1'b1;
                ModeBlink:  on = (phase_q < (eff_per >> 1));
                ModeStrobe: on = (phase_q == '0);
                default:    on = 1'b0;
            endcase
            led_d = on ^ ACTIVE_LOW;
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                mode_q   <= ResetMode;
                period_q <= ResetPer;
                phase_q  <= '0;
                led_q    <= ACTIVE_LOW;
            end else begin
                mode_q   <= mode_d;
                period_q <= period_d;
                phase_q  <= phase_d;
                led_q    <= led_d;
            end
        end

        assign LED[gi] = led_q;
    end

endmodule

// File: tb/tb_led_pattern.sv
// Directed bench: two instances (active-high and active-low) driven in lockstep,
// checked against hand-computed LED and tick values.
module tb_led_pattern;
    import led_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [1:0] wr_mode;
    logic [7:0] wr_period;
    logic [2:0] led, led_n;
    logic       tick, tick_n;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    led_pattern #(
        .CLK_FREQ(100), .TICK_HZ(10), .NUM_CH(3), .PER_W(8),
        .RESET_MODE(2), .RESET_PERIOD(4), .ACTIVE_LOW(1'b0)
    ) u_dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
        .wr_period(wr_period), .LED(led), .tick(tick)
    );

    led_pattern #(
        .CLK_FREQ(100), .TICK_HZ(10), .NUM_CH(3), .PER_W(8),
        .RESET_MODE(2), .RESET_PERIOD(4), .ACTIVE_LOW(1'b1)
    ) u_dut_n (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
        .wr_period(wr_period), .LED(led_n), .tick(tick_n)
    );

    task automatic go(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_led(input string tag, input logic [2:0] exp);
        logic [2:0] exp_n;
        exp_n = ~exp;
        checks++;
        assert (led === exp) else begin
            errors++;
            $error("FAIL %s: LED observed %b expected %b", tag, led, exp);
        end
        checks++;
        assert (led_n === exp_n) else begin
            errors++;
            $error("FAIL %s_n: LED observed %b expected %b", tag, led_n, exp_n);
        end
    endtask

    task automatic chk_tick(input string tag, input logic exp);
        checks++;
        assert (tick === exp) else begin
            errors++;
            $error("FAIL %s: tick observed %b expected %b", tag, tick, exp);
        end
        checks++;
        assert (tick_n === exp) else begin
            errors++;
            $error("FAIL %s_n: tick observed %b expected %b", tag, tick_n, exp);
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] per);
        wr_ch     = ch;
        wr_mode   = mode;
        wr_period = per;
        wr_en     = 1'b1;
        go(1);
        wr_en     = 1'b0;
    endtask

    initial begin
        RST = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_mode = '0; wr_period = '0;
        go(3);
        chk_led("reset_led", 3'b000);
        chk_tick("reset_tick", 1'b0);

        // Edge k after release: phase = floor(k/10) mod 4, LED shows phase of edge k-1.
        RST = 1'b0;
        go(8);  chk_tick("tick_k8", 1'b0);
        go(1);  chk_tick("tick_k9", 1'b1);  chk_led("blink_k9", 3'b111);
        go(1);  chk_tick("tick_k10", 1'b0); chk_led("blink_k10", 3'b111);
        go(11); chk_led("blink_k21", 3'b000);
        go(20); chk_led("blink_k41", 3'b111);

        write(2'd1, ModeStrobe, 8'd5);
        go(1);  chk_led("strobe_k43", 3'b111);
        go(8);  chk_led("strobe_k51", 3'b101);
        go(10); chk_led("strobe_k61", 3'b000);
        go(30); chk_led("strobe_k91", 3'b111);
        go(10); chk_led("strobe_k101", 3'b000);

        write(2'd2, ModeBlink, 8'd0);
        go(1);  chk_led("per0_k103", 3'b100);
        go(8);  chk_led("per0_k111", 3'b000);
        go(10); chk_led("per0_k121", 3'b101);
        write(2'd2, ModeBlink, 8'd1);
        go(1);  chk_led("per1_k123", 3'b101);
        go(8);  chk_led("per1_k131", 3'b001);
        write(2'd0, ModeOff, 8'd4);
        chk_led("off_edge1", 3'b001);
        go(1);  chk_led("off_edge2", 3'b000);

        go(6);  chk_tick("tick_k139", 1'b1);
        write(2'd0, ModeBlink, 8'd6);
        go(1);  chk_led("wr_tick_k141", 3'b111);
        go(20); chk_led("wr_tick_k161", 3'b101);
        go(10); chk_led("wr_tick_k171", 3'b000);
        go(20); chk_led("wr_tick_k191", 3'b010);
        go(10); chk_led("wr_tick_k201", 3'b101);

        wr_ch = 2'd3; wr_mode = ModeOff; wr_period = 8'd2; wr_en = 1'b1;
        go(10);
        wr_en = 1'b0;
        chk_led("bad_ch_k211", 3'b001);
        go(8);  chk_tick("bad_ch_tick_k219", 1'b1);
        go(2);  chk_led("bad_ch_k221", 3'b101);

        // Reset mid-pattern, with a competing write that must lose.
        go(3);
        RST = 1'b1; wr_ch = 2'd0; wr_mode = ModeOff; wr_period = 8'd6; wr_en = 1'b1;
        go(1);
        wr_en = 1'b0;
        chk_led("rst_mid_led", 3'b000);
        chk_tick("rst_mid_tick", 1'b0);
        go(4);  chk_tick("rst_hold_tick", 1'b0); chk_led("rst_hold_led", 3'b000);

        RST = 1'b0;
        go(1);  chk_led("rerel_k1", 3'b111);
        go(8);  chk_tick("rerel_tick_k9", 1'b1);
        go(12); chk_led("rerel_k21", 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
